// File: rtl/ctrl_pkg.sv
// Shared definitions for the microcore control FSM: state codes, opcode
// classes and the per-state datapath enable decode.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_PC        = 4'd0,
    S_FETCH     = 4'd1,
    S_LDR       = 4'd2,
    S_ARIT      = 4'd3,
    S_WB_RD     = 4'd4,
    S_LOGIC     = 4'd5,
    S_WB_R0     = 4'd6,
    S_JMP       = 4'd7,
    S_STEP_WAIT = 4'd8,
    S_HALT      = 4'd9,
    S_ERR       = 4'd10
  } state_t;

  localparam logic [2:0] OP_LDR   = 3'b000;
  localparam logic [2:0] OP_LOGIC = 3'b001;
  localparam logic [2:0] OP_ARIT0 = 3'b010;
  localparam logic [2:0] OP_ARIT1 = 3'b011;
  localparam logic [2:0] OP_JMP   = 3'b100;
  localparam logic [2:0] OP_NOP   = 3'b101;
  localparam logic [2:0] OP_ILL   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef struct packed {
    logic ena_pc;
    logic ena_ri;
    logic ena_wr;
    logic ena_ula;
    logic ld_pc;
    logic sel_r0_rd;
    logic sel_addr_data;
    logic sel_ldr_ula;
    logic err;
  } ctrl_out_t;

  function automatic ctrl_out_t decode_outs(input state_t s);
    ctrl_out_t o;
    o = '0;
    case (s)
      S_PC:    o.ena_pc = 1'b1;
      S_FETCH: o.ena_ri = 1'b1;
      S_LDR: begin
        o.ena_wr      = 1'b1;
        o.sel_r0_rd   = 1'b1;
        o.sel_ldr_ula = 1'b1;
      end
      S_ARIT, S_LOGIC: begin
        o.sel_addr_data = 1'b1;
        o.ena_ula       = 1'b1;
      end
      S_WB_RD: begin
        o.ena_wr    = 1'b1;
        o.sel_r0_rd = 1'b1;
      end
      S_WB_R0: o.ena_wr = 1'b1;
      S_JMP: begin
        o.ena_pc = 1'b1;
        o.ld_pc  = 1'b1;
      end
      S_ERR:   o.err = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic logic is_watched(input state_t s);
    return s inside {S_PC, S_FETCH, S_LDR, S_ARIT, S_WB_RD, S_LOGIC, S_WB_R0, S_JMP};
  endfunction

endpackage

// File: rtl/ctrl_fsm_gen_ack_watchdog.sv
// Handshake watchdog: counts cycles spent in a watched state and flags the
// last cycle before the ack budget runs out.
module ack_watchdog #(
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned TO_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic watch,
  input  logic restart,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(ACK_TIMEOUT == 0 ? 0 : ACK_TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (watch && (cnt != '1)) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  assign expired = (ACK_TIMEOUT != 0) && watch && (cnt == LIMIT);

endmodule

// File: rtl/ctrl_fsm_gen.sv
// Microcore control FSM: PC -> fetch -> execute -> writeback sequencing with
// handshake watchdog, single-step, halt/error parking and retire counting.
module ctrl_fsm_gen
  import ctrl_pkg::*;
#(
  parameter int unsigned MNM_W       = 3,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned TO_W        = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MNM_W-1:0] mnm_in,
  input  logic             pc_ack,
  input  logic             ri_ack,
  input  logic             ula_ack,
  input  logic             wr_ack,
  input  logic             step_en,
  input  logic             step,
  input  logic             resume,
  input  logic             clr_err,
  output logic             ena_pc,
  output logic             ena_ri,
  output logic             ena_wr,
  output logic             ena_ula,
  output logic             ld_pc,
  output logic             sel_r0_rd,
  output logic             sel_addr_data,
  output logic             sel_ldr_ula,
  output logic             err,
  output logic [3:0]       err_state,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_out
);

  state_t    state, state_nxt;
  ctrl_out_t outs_q;
  logic      expired;
  logic      retire;
  logic [2:0] op;
  logic      unused_mnm;

  assign op         = mnm_in[2:0];
  assign unused_mnm = ^mnm_in;

  ack_watchdog #(
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .TO_W        (TO_W)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .watch   (is_watched(state)),
    .restart (state_nxt != state),
    .expired (expired)
  );

  // Each handshake state tests its own ack first so an ack arriving in the
  // timeout cycle still advances normally.
  always_comb begin
    state_nxt = state;
    case (state)
      S_PC: begin
        if (pc_ack)       state_nxt = (step_en && !step) ? S_STEP_WAIT : S_FETCH;
        else if (expired) state_nxt = S_ERR;
      end
      S_STEP_WAIT: if (step) state_nxt = S_FETCH;
      S_FETCH: begin
        if (ri_ack) begin
          case (op)
            OP_LDR:             state_nxt = S_LDR;
            OP_LOGIC:           state_nxt = S_LOGIC;
            OP_ARIT0, OP_ARIT1: state_nxt = S_ARIT;
            OP_JMP:             state_nxt = S_JMP;
            OP_NOP:             state_nxt = S_PC;
            OP_ILL:             state_nxt = S_ERR;
            default:            state_nxt = S_HALT;
          endcase
        end else if (expired) begin
          state_nxt = S_ERR;
        end
      end
      S_LDR, S_WB_RD, S_WB_R0: begin
        if (wr_ack)       state_nxt = S_PC;
        else if (expired) state_nxt = S_ERR;
      end
      S_ARIT: begin
        if (ula_ack)      state_nxt = S_WB_RD;
        else if (expired) state_nxt = S_ERR;
      end
      S_LOGIC: begin
        if (ula_ack)      state_nxt = S_WB_R0;
        else if (expired) state_nxt = S_ERR;
      end
      S_JMP: begin
        if (pc_ack)       state_nxt = S_FETCH;
        else if (expired) state_nxt = S_ERR;
      end
      S_HALT:  if (resume)  state_nxt = S_PC;
      S_ERR:   if (clr_err) state_nxt = S_FETCH;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    if (state_nxt == S_PC && (state inside {S_LDR, S_WB_RD, S_WB_R0, S_FETCH}))
      retire = 1'b1;
    if (state == S_JMP && state_nxt == S_FETCH)
      retire = 1'b1;
  end

  // Outputs are decoded from the next state so they stay Moore yet registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      outs_q    <= decode_outs(S_FETCH);
      err_state <= '0;
      retired   <= '0;
    end else begin
      state  <= state_nxt;
      outs_q <= decode_outs(state_nxt);
      if (state_nxt == S_ERR && state != S_ERR)
        err_state <= state;
      if (retire)
        retired <= retired + CNT_W'(1);
    end
  end

  assign ena_pc        = outs_q.ena_pc;
  assign ena_ri        = outs_q.ena_ri;
  assign ena_wr        = outs_q.ena_wr;
  assign ena_ula       = outs_q.ena_ula;
  assign ld_pc         = outs_q.ld_pc;
  assign sel_r0_rd     = outs_q.sel_r0_rd;
  assign sel_addr_data = outs_q.sel_addr_data;
  assign sel_ldr_ula   = outs_q.sel_ldr_ula;
  assign err           = outs_q.err;
  assign state_out     = state;

endmodule

// File: tb/tb_ctrl_fsm_gen.sv
// Directed bench for ctrl_fsm_gen: a vector table for the instruction flows
// plus hand sequences for watchdog, single-step park and async reset.
module tb_ctrl_fsm_gen;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mnm_in;
  logic       pc_ack, ri_ack, ula_ack, wr_ack, step_en, step, resume, clr_err;
  logic       ena_pc, ena_ri, ena_wr, ena_ula, ld_pc;
  logic       sel_r0_rd, sel_addr_data, sel_ldr_ula, err;
  logic [3:0] err_state, state_out;
  logic [1:0] retired;

  int total = 0;
  int bad   = 0;

  ctrl_fsm_gen #(
    .MNM_W       (4),
    .ACK_TIMEOUT (15),
    .TO_W        (4),
    .CNT_W       (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mnm_in        (mnm_in),
    .pc_ack        (pc_ack),
    .ri_ack        (ri_ack),
    .ula_ack       (ula_ack),
    .wr_ack        (wr_ack),
    .step_en       (step_en),
    .step          (step),
    .resume        (resume),
    .clr_err       (clr_err),
    .ena_pc        (ena_pc),
    .ena_ri        (ena_ri),
    .ena_wr        (ena_wr),
    .ena_ula       (ena_ula),
    .ld_pc         (ld_pc),
    .sel_r0_rd     (sel_r0_rd),
    .sel_addr_data (sel_addr_data),
    .sel_ldr_ula   (sel_ldr_ula),
    .err           (err),
    .err_state     (err_state),
    .retired       (retired),
    .state_out     (state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mnm;
    logic       pc, ri, ula, wr, sen, stp, res, clr;
    logic [3:0] st;
    logic [1:0] ret;
    logic [3:0] es;
  } vec_t;

  vec_t vt[29];

  // {ena_pc, ena_ri, ena_wr, ena_ula, ld_pc, sel_r0_rd, sel_addr_data, sel_ldr_ula, err}
  function automatic logic [8:0] exp_outs(input logic [3:0] s);
    case (s)
      4'd0:       return 9'b100000000;
      4'd1:       return 9'b010000000;
      4'd2:       return 9'b001001010;
      4'd3, 4'd5: return 9'b000100100;
      4'd4:       return 9'b001001000;
      4'd6:       return 9'b001000000;
      4'd7:       return 9'b100010000;
      4'd10:      return 9'b000000001;
      default:    return 9'b000000000;
    endcase
  endfunction

  function automatic logic [8:0] dut_outs();
    return {ena_pc, ena_ri, ena_wr, ena_ula, ld_pc, sel_r0_rd, sel_addr_data, sel_ldr_ula, err};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] st, input logic [1:0] ret,
                         input logic [3:0] es);
    chk({tag, " state"}, 32'(state_out), 32'(st));
    chk({tag, " outs"}, 32'(dut_outs()), 32'(exp_outs(st)));
    chk({tag, " retired"}, 32'(retired), 32'(ret));
    chk({tag, " err_state"}, 32'(err_state), 32'(es));
  endtask

  task automatic idle();
    pc_ack = 0; ri_ack = 0; ula_ack = 0; wr_ack = 0;
    step = 0; resume = 0; clr_err = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //         mnm            pc ri ul wr se st rs cl  st  ret es
    vt[0]  = '{{1'b0, OP_LDR},   0, 1, 0, 0, 0, 0, 0, 0, 4'd2, 2'd0, 4'd0};
    vt[1]  = '{4'd0,             0, 0, 0, 1, 0, 0, 0, 0, 4'd0, 2'd1, 4'd0};
    vt[2]  = '{4'd0,             1, 0, 0, 0, 0, 0, 0, 0, 4'd1, 2'd1, 4'd0};
    vt[3]  = '{{1'b0, OP_ARIT1}, 0, 1, 0, 0, 0, 0, 0, 0, 4'd3, 2'd1, 4'd0};
    vt[4]  = '{4'd0,             0, 0, 0, 1, 0, 0, 0, 0, 4'd3, 2'd1, 4'd0};
    vt[5]  = '{4'd0,             1, 1, 0, 0, 0, 0, 0, 0, 4'd3, 2'd1, 4'd0};
    vt[6]  = '{4'd0,             0, 0, 1, 0, 0, 0, 0, 0, 4'd4, 2'd1, 4'd0};
    vt[7]  = '{4'd0,             0, 0, 0, 1, 0, 0, 0, 0, 4'd0, 2'd2, 4'd0};
    vt[8]  = '{4'd0,             1, 0, 0, 0, 0, 0, 0, 0, 4'd1, 2'd2, 4'd0};
    vt[9]  = '{{1'b0, OP_LOGIC}, 0, 1, 0, 0, 0, 0, 0, 0, 4'd5, 2'd2, 4'd0};
    vt[10] = '{4'd0,             0, 0, 1, 1, 0, 0, 0, 0, 4'd6, 2'd2, 4'd0};
    vt[11] = '{4'd0,             0, 0, 0, 1, 0, 0, 0, 0, 4'd0, 2'd3, 4'd0};
    vt[12] = '{4'd0,             1, 0, 0, 0, 0, 0, 0, 0, 4'd1, 2'd3, 4'd0};
    vt[13] = '{{1'b0, OP_JMP},   0, 1, 0, 0, 0, 0, 0, 0, 4'd7, 2'd3, 4'd0};
    vt[14] = '{4'd0,             0, 1, 1, 1, 0, 0, 0, 0, 4'd7, 2'd3, 4'd0};
    vt[15] = '{4'd0,             1, 0, 0, 0, 0, 0, 0, 0, 4'd1, 2'd0, 4'd0};
    vt[16] = '{{1'b0, OP_NOP},   0, 1, 0, 0, 0, 0, 0, 0, 4'd0, 2'd1, 4'd0};
    vt[17] = '{4'd0,             1, 0, 0, 0, 0, 0, 0, 0, 4'd1, 2'd1, 4'd0};
    vt[18] = '{{1'b0, OP_ILL},   0, 1, 0, 0, 0, 0, 0, 0, 4'd10, 2'd1, 4'd1};
    vt[19] = '{4'd0,             1, 1, 1, 1, 0, 0, 1, 0, 4'd10, 2'd1, 4'd1};
    vt[20] = '{4'd0,             0, 0, 0, 0, 0, 0, 0, 1, 4'd1, 2'd1, 4'd1};
    vt[21] = '{4'b1101,          0, 1, 0, 0, 0, 0, 0, 0, 4'd0, 2'd2, 4'd1};
    vt[22] = '{4'd0,             1, 0, 0, 0, 1, 0, 0, 0, 4'd8, 2'd2, 4'd1};
    vt[23] = '{4'd0,             1, 1, 0, 0, 1, 0, 0, 0, 4'd8, 2'd2, 4'd1};
    vt[24] = '{4'd0,             0, 0, 0, 0, 1, 1, 0, 0, 4'd1, 2'd2, 4'd1};
    vt[25] = '{{1'b0, OP_HALT},  0, 1, 0, 0, 0, 0, 0, 0, 4'd9, 2'd2, 4'd1};
    vt[26] = '{4'd0,             1, 1, 1, 1, 0, 0, 0, 1, 4'd9, 2'd2, 4'd1};
    vt[27] = '{4'd0,             0, 0, 0, 0, 0, 0, 1, 0, 4'd0, 2'd2, 4'd1};
    vt[28] = '{4'd0,             1, 0, 0, 0, 0, 0, 0, 0, 4'd1, 2'd2, 4'd1};

    rst = 1'b0; mnm_in = '0; step_en = 0;
    idle();
    tick(); tick();
    chk_all("reset", 4'd1, 2'd0, 4'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 29; i++) begin
      mnm_in = vt[i].mnm;
      pc_ack = vt[i].pc; ri_ack = vt[i].ri; ula_ack = vt[i].ula; wr_ack = vt[i].wr;
      step_en = vt[i].sen; step = vt[i].stp; resume = vt[i].res; clr_err = vt[i].clr;
      tick();
      chk_all($sformatf("vec%0d", i), vt[i].st, vt[i].ret, vt[i].es);
    end
    idle(); step_en = 0;

    // Watchdog expiry in ARIT: 15 edges after entry with no ula_ack
    mnm_in = {1'b0, OP_ARIT0}; ri_ack = 1; tick(); idle();
    for (int k = 1; k < 15; k++) tick();
    chk("wd_pre state", 32'(state_out), 32'd3);
    tick();
    chk_all("wd_to", 4'd10, 2'd2, 4'd3);
    clr_err = 1; tick(); idle();
    chk_all("wd_clr", 4'd1, 2'd2, 4'd3);

    // Ack in the final allowed cycle wins over the timeout
    mnm_in = {1'b0, OP_ARIT0}; ri_ack = 1; tick(); idle();
    for (int k = 1; k < 15; k++) tick();
    ula_ack = 1; tick(); idle();
    chk_all("wd_ack", 4'd4, 2'd2, 4'd3);
    wr_ack = 1; tick(); idle();
    chk_all("wd_wb", 4'd0, 2'd3, 4'd3);
    pc_ack = 1; tick(); idle();
    chk_all("wd_pc", 4'd1, 2'd3, 4'd3);

    // Single-step park survives well past the ack timeout
    step_en = 1;
    mnm_in = {1'b0, OP_NOP}; ri_ack = 1; tick(); idle();
    chk_all("ss_nop", 4'd0, 2'd0, 4'd3);
    pc_ack = 1; tick(); idle();
    for (int k = 0; k < 20; k++) tick();
    chk_all("ss_park", 4'd8, 2'd0, 4'd3);
    step = 1; tick(); idle(); step_en = 0;
    chk_all("ss_go", 4'd1, 2'd0, 4'd3);

    // Asynchronous reset mid-instruction
    mnm_in = {1'b0, OP_ARIT1}; ri_ack = 1; tick(); idle();
    chk("rst_pre state", 32'(state_out), 32'd3);
    #2 rst = 1'b0;
    #1;
    chk_all("rst_mid", 4'd1, 2'd0, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk_all("rst_rel", 4'd1, 2'd0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm_gen.md
Name: ctrl_fsm_gen

Overview:
- Parametrised successor of the microcore control FSM.
- Sequences PC → Fetch → execute → writeback using ack handshakes with the PC, IR, ALU and register bank.
- Adds wider mnemonics, jump/NOP/halt classes, per-state handshake watchdog with error capture, single-step mode and a retired-instruction counter.
- Sits between the instruction register (mnemonic source) and the datapath enables.

Parameters:
- MNM_W, 3, mnemonic field width; must be ≥3, decode uses mnm_in[2:0], upper bits ignored.
- ACK_TIMEOUT, 15, max cycles spent in a handshake state without its ack; 0 disables the watchdog.
- TO_W, 4, watchdog counter width; must satisfy 2^TO_W > ACK_TIMEOUT.
- CNT_W, 8, retired-instruction counter width.

Ports:
- clk  in  1  clock
- rst  in  1  async active-low reset
- mnm_in  in  MNM_W  instruction mnemonic field
- pc_ack, ri_ack, ula_ack, wr_ack  in  1 each  PC / IR / ALU / bank handshake done
- step_en  in  1  single-step mode enable
- step  in  1  single-step advance pulse
- resume  in  1  leave HALT
- clr_err  in  1  leave ERR
- ena_pc, ena_ri, ena_wr, ena_ula  out  1 each  unit enables
- ld_pc  out  1  PC parallel load (jump)
- sel_r0_rd, sel_addr_data, sel_ldr_ula  out  1 each  datapath selects
- err  out  1  high in ERR
- err_state  out  4  state code captured at fault
- retired  out  CNT_W  retired-instruction count
- state_out  out  4  current state code for display

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst).
- On rst low: state=FETCH, watchdog=0, err_state=0, retired=0. Outputs are Moore (decoded from state), so their reset values are the FETCH values: ena_ri=1, all others 0.
- State codes: PC=0, FETCH=1, LDR=2, ARIT=3, WB_RD=4, LOGIC=5, WB_R0=6, JMP=7, STEP_WAIT=8, HALT=9, ERR=10.
- Transitions:
  - PC: on pc_ack → FETCH, or STEP_WAIT if step_en && !step.
  - STEP_WAIT: on step → FETCH.
  - FETCH: on ri_ack, decode mnm_in[2:0]: 000→LDR, 001→LOGIC, 010/011→ARIT, 100→JMP, 101 (NOP)→PC, 110 (illegal)→ERR, 111→HALT.
  - LDR: on wr_ack → PC.
  - ARIT: on ula_ack → WB_RD; WB_RD: on wr_ack → PC.
  - LOGIC: on ula_ack → WB_R0; WB_R0: on wr_ack → PC.
  - JMP: on pc_ack → FETCH.
  - HALT: on resume → PC.
  - ERR: on clr_err → FETCH.
  - Unused codes → FETCH.
- Outputs asserted per state (all others 0):
  - PC: ena_pc.
  - FETCH: ena_ri.
  - LDR: ena_wr, sel_r0_rd, sel_ldr_ula.
  - ARIT, LOGIC: sel_addr_data, ena_ula.
  - WB_RD: ena_wr, sel_r0_rd.
  - WB_R0: ena_wr.
  - JMP: ena_pc, ld_pc.
  - ERR: err.
- Watchdog:
  - Applies in PC, FETCH, LDR, ARIT, WB_RD, LOGIC, WB_R0 and JMP.
  - Counter clears on every state change and increments each cycle the FSM stays in a watched state.
  - If count == ACK_TIMEOUT-1 and the relevant ack is low, next state = ERR and err_state captures the current state code.
  - Ack and timeout in the same cycle: ack wins.
  - Not active in STEP_WAIT, HALT or ERR.
- Illegal opcode: err_state is loaded with FETCH (1).
- retired: increments by 1 on each edge into PC from LDR, WB_RD, WB_R0 or FETCH (NOP), and on JMP→FETCH. Wraps modulo 2^CNT_W. HALT and ERR entries do not count.
- Any ack in a state that does not consume it is ignored.
- Acks are level-sampled. A single-cycle ack arriving in the entry cycle of a state is honoured.
- rst mid-instruction aborts immediately to FETCH. Counters are lost.

Decomposition:
- Shared package ctrl_pkg holds the 4-bit state enum/localparams and the 3-bit opcode constants (OP_LDR, OP_LOGIC, OP_ARIT0/1, OP_JMP, OP_NOP, OP_ILL, OP_HALT), reused by the display decoder and the bench.
- One natural sub-module: ack_watchdog (counter, clear-on-change, timeout flag, parameters ACK_TIMEOUT/TO_W).

Test Plan:
- Reset then mnm=000 with one-cycle ri_ack, wr_ack, pc_ack → states 1,2,0,1. ena_wr/sel_r0_rd/sel_ldr_ula high in LDR. retired 0→1 on entry to PC.
- mnm=011, ula_ack after 3 cycles, wr_ack → 1,3,4,0. sel_addr_data+ena_ula held 3+ cycles in ARIT. ena_wr+sel_r0_rd in WB_RD.
- mnm=110 with ri_ack → ERR, err=1, err_state=1. clr_err → FETCH, err=0.
- In ARIT hold ula_ack low (ACK_TIMEOUT=15) → ERR exactly 15 cycles after entry, err_state=3. Repeat with ula_ack rising on cycle 15 → WB_RD, no error.
- step_en=1: after pc_ack FSM parks in STEP_WAIT(8) indefinitely. step pulse → FETCH. mnm=111 → HALT(9), no retire. resume → PC.
- CNT_W=2: 5 NOP instructions → retired 1,2,3,0,1. mnm=100 → JMP with ena_pc+ld_pc; pc_ack → FETCH, retired incremented.
